cotm32_uart: RTL

//  Memory-mapped UART responder serving LSU accesses to the UART window (0x1000_0000-0x1000_00FF).

---
 rtl/cotm32_uart.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cotm32_uart.sv
`timescale 1ns/1ps
// cotm32_uart: memory-mapped 8N1 UART responder.
// Stores to TXDATA go into a small TX FIFO that feeds the serializer on uart_tx.
// The deserializer on uart_rx fills a one-byte holding register read through RXDATA.
// STATUS reports FIFO, RX and error flags.
module cotm32_uart #(
    parameter int unsigned CLKS_PER_BIT  = 434,
    parameter int unsigned TX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic [7:0]  addr,
    input  logic        wen,
    input  logic        ren,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // TX FIFO and serializer state
    logic [7:0]    fifo_mem_q [TX_FIFO_DEPTH];
    logic [7:0]    fifo_mem_d [TX_FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_out_q, tx_out_d;

    // RX synchronizer, deserializer and holding register state
    logic          rx_sync1_q, rx_sync1_d;
    logic          rx_sync2_q, rx_sync2_d;
    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_valid_q, rx_valid_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;

    logic fifo_empty, fifo_full, tx_idle;
    logic tx_pop, tx_push;
    logic bus_tx_wr, bus_rx_rd;
    logic rx_s, rx_deliver, rx_stop_bad;
    logic unused_wdata;

    assign unused_wdata = ^wdata[31:8];

    assign bus_tx_wr  = sel && wen && (addr == 8'h00);
    assign bus_rx_rd  = sel && ren && (addr == 8'h04);

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tx_idle    = fifo_empty && (tx_state_q == TX_IDLE);
    assign rx_s       = rx_sync2_q;
    assign uart_tx    = tx_out_q;

    // TX FIFO bookkeeping and serializer next state
    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_out_d   = tx_out_q;
        tx_pop     = 1'b0;

        unique case (tx_state_q)
            TX_IDLE: begin
                if (!fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = fifo_mem_q[rd_ptr_q[AW-1:0]];
                    tx_state_d = TX_START;
                    tx_cnt_d   = '0;
                    tx_out_d   = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_out_d   = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                        tx_out_d   = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_out_d   = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_state_d = TX_IDLE;
                    tx_cnt_d   = '0;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        // A pop in the same cycle frees the head slot, so a push into a full FIFO still lands.
        tx_push = bus_tx_wr && (!fifo_full || tx_pop);
        if (tx_push) begin
            fifo_mem_d[wr_ptr_q[AW-1:0]] = wdata[7:0];
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // RX synchronizer, deserializer next state and holding-register flags
    always_comb begin
        rx_sync1_d  = uart_rx;
        rx_sync2_d  = rx_sync1_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_byte_d   = rx_byte_q;
        rx_valid_d  = rx_valid_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        rx_deliver  = 1'b0;
        rx_stop_bad = 1'b0;

        unique case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_state_d  = RX_IDLE;
                    rx_cnt_d    = '0;
                    rx_deliver  = rx_s;
                    rx_stop_bad = !rx_s;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        if (bus_rx_rd) begin
            rx_valid_d  = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end

        // A delivery coinciding with an RXDATA read replaces the byte and leaves overrun as it was.
        if (rx_deliver) begin
            if (!rx_valid_q || bus_rx_rd) begin
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                if (bus_rx_rd) begin
                    overrun_d = overrun_q;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (rx_stop_bad) begin
            frame_err_d = 1'b1;
        end
    end

    // Load data decode
    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                8'h04:   rdata = {24'h0, rx_valid_q ? rx_byte_q : 8'h00};
                8'h08:   rdata = {27'h0, frame_err_q, overrun_q, rx_valid_q, tx_idle, fifo_full};
                default: rdata = '0;
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fifo_mem_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_shift_q  <= '0;
            tx_out_q    <= 1'b1;
            rx_sync1_q  <= 1'b1;
            rx_sync2_q  <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_shift_q  <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            fifo_mem_q  <= fifo_mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_shift_q  <= tx_shift_d;
            tx_out_q    <= tx_out_d;
            rx_sync1_q  <= rx_sync1_d;
            rx_sync2_q  <= rx_sync2_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_shift_q  <= rx_shift_d;
            rx_byte_q   <= rx_byte_d;
            rx_valid_q  <= rx_valid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

endmodule
